// File: rtl/instruction_fetch_stage_if.sv
// Bundle between the fetch stage, the hazard unit, branch resolution and instruction memory.
// With FETCH_PERF_CNT_EN defined it also carries the fetch and bubble counters.
interface instruction_fetch_stage_if #(
    parameter int ADDR_W = 6
);
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic [31:0]       pc_f;
    logic [31:0]       instr_d;
    logic [31:0]       pc_plus4_d;
    logic              valid_d;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       fetch_count;
    logic [31:0]       bubble_count;
`endif

    // Fetch stage side
    modport master (
        input  stall_f, stall_d, flush_d, redirect, redirect_pc, imem_instr,
`ifdef FETCH_PERF_CNT_EN
        output fetch_count, bubble_count,
`endif
        output imem_addr, pc_f, instr_d, pc_plus4_d, valid_d
    );

    // Environment side: hazard unit, branch resolution, memory, decode
    modport slave (
        output stall_f, stall_d, flush_d, redirect, redirect_pc, imem_instr,
`ifdef FETCH_PERF_CNT_EN
        input  fetch_count, bubble_count,
`endif
        input  imem_addr, pc_f, instr_d, pc_plus4_d, valid_d
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC register, instruction memory addressing and IF/ID pipeline register.
// Optional perf counters (fetch_count, bubble_count) are built when FETCH_PERF_CNT_EN is defined.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 6
) (
    input  logic                          clk,
    input  logic                          reset_n,
    instruction_fetch_stage_if.master     bus
);

    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] instr_r;
    logic [31:0] instr_next_s;
    logic [31:0] pc_plus4_d_r;
    logic [31:0] pc_plus4_d_next_s;
    logic        valid_r;
    logic        valid_next_s;
    logic        capture_s;

    // PC next-value selection: redirect beats stall, otherwise sequential
    always_comb begin
        pc_plus4_s = pc_r + 32'd4;
        pc_next_s  = pc_plus4_s;
        if (bus.redirect) begin
            pc_next_s = {bus.redirect_pc[31:2], 2'b00};
        end else if (bus.stall_f) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // IF/ID next-value selection: flush inserts a bubble even while stalled
    always_comb begin
        instr_next_s      = instr_r;
        pc_plus4_d_next_s = pc_plus4_d_r;
        valid_next_s      = valid_r;
        capture_s         = 1'b0;
        if (bus.flush_d) begin
            instr_next_s      = 32'h0000_0000;
            pc_plus4_d_next_s = 32'h0000_0000;
            valid_next_s      = 1'b0;
        end else if (bus.stall_d) begin
            instr_next_s      = instr_r;
            pc_plus4_d_next_s = pc_plus4_d_r;
            valid_next_s      = valid_r;
        end else begin
            instr_next_s      = bus.imem_instr;
            pc_plus4_d_next_s = pc_plus4_s;
            valid_next_s      = 1'b1;
            capture_s         = 1'b1;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_r      <= 32'h0000_0000;
            pc_plus4_d_r <= 32'h0000_0000;
            valid_r      <= 1'b0;
        end else begin
            instr_r      <= instr_next_s;
            pc_plus4_d_r <= pc_plus4_d_next_s;
            valid_r      <= valid_next_s;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_r;
    logic [31:0] bubble_count_r;

    // Perf counters, free-running with natural 32-bit wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_r  <= 32'd0;
            bubble_count_r <= 32'd0;
        end else begin
            if (capture_s) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end else begin
                fetch_count_r <= fetch_count_r;
            end
            if (bus.flush_d || bus.stall_d) begin
                bubble_count_r <= bubble_count_r + 32'd1;
            end else begin
                bubble_count_r <= bubble_count_r;
            end
        end
    end

    assign bus.fetch_count  = fetch_count_r;
    assign bus.bubble_count = bubble_count_r;
`endif

    // Word address aliases modulo the memory size; no range check by design
    assign bus.imem_addr  = pc_r[ADDR_W+1:2];
    assign bus.pc_f       = pc_r;
    assign bus.instr_d    = instr_r;
    assign bus.pc_plus4_d = pc_plus4_d_r;
    assign bus.valid_d    = valid_r;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed plan scenarios then randomized
// control traffic against a reference model built from the PC and IF/ID priority rules.
module tb_instruction_fetch_stage;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    logic [31:0] mem [64];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pp4;
    logic        m_valid;
    logic [31:0] m_fc;
    logic [31:0] m_bc;

    instruction_fetch_stage_if #(.ADDR_W(6)) bus ();

    instruction_fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.imem_instr = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
        int idx;
        idx = int'((byte_addr / 32'd4) % 32'd64);
        return mem[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_0000;
        m_instr = 32'h0;
        m_pp4   = 32'h0;
        m_valid = 1'b0;
        m_fc    = 32'h0;
        m_bc    = 32'h0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc_f"}, bus.pc_f, m_pc);
        chk({tag, ".imem_addr"}, {26'd0, bus.imem_addr}, (m_pc / 32'd4) % 32'd64);
        chk({tag, ".instr_d"}, bus.instr_d, m_instr);
        chk({tag, ".pc_plus4_d"}, bus.pc_plus4_d, m_pp4);
        chk({tag, ".valid_d"}, {31'd0, bus.valid_d}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".fetch_count"}, bus.fetch_count, m_fc);
        chk({tag, ".bubble_count"}, bus.bubble_count, m_bc);
`endif
    endtask

    // One clock: apply controls, advance the model by the spec rules, compare 1 time unit later
    task automatic step(input string tag, input logic sf, input logic sd, input logic fl,
                        input logic rd, input logic [31:0] rpc);
        logic [31:0] fetched;
        bus.stall_f     = sf;
        bus.stall_d     = sd;
        bus.flush_d     = fl;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        @(posedge clk);
        fetched = mem_word(m_pc);
        if (fl) begin
            m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_bc = m_bc + 32'd1;
        end else if (sd) begin
            m_bc = m_bc + 32'd1;
        end else begin
            m_instr = fetched; m_pp4 = m_pc + 32'd4; m_valid = 1'b1; m_fc = m_fc + 32'd1;
        end
        if (rd)       m_pc = rpc - (rpc % 32'd4);
        else if (!sf) m_pc = m_pc + 32'd4;
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        reset_n         = 1'b0;
        bus.stall_f     = 1'b0;
        bus.stall_d     = 1'b0;
        bus.flush_d     = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Sequential fetch
        for (int i = 0; i < 3; i++) step("seq", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("seq.pc_is_0c", bus.pc_f, 32'h0000_000C);
        chk("seq.word2", bus.instr_d, mem[2]);
        chk("seq.pp4", bus.pc_plus4_d, 32'h0000_000C);

        // Stall both stages for three cycles at PC 0x0C
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("stall.pc_hold", bus.pc_f, 32'h0000_000C);
            chk("stall.instr_hold", bus.instr_d, mem[2]);
        end
        step("resume1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("resume.word3", bus.instr_d, mem[3]);
        step("resume2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("resume.word4", bus.instr_d, mem[4]);

        // Redirect with flush from PC 0x08
        async_reset("rst1");
        step("to8a", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("to8b", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("redir", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0023);
        chk("redir.pc", bus.pc_f, 32'h0000_0020);
        chk("redir.bubble", {31'd0, bus.valid_d}, 32'd0);
        step("redir.next", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir.word8", bus.instr_d, mem[8]);

        // Simultaneous events
        step("rd_sf", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0054);
        chk("rd_sf.pc", bus.pc_f, 32'h0000_0054);
        step("fl_sd", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("fl_sd.valid", {31'd0, bus.valid_d}, 32'd0);

        // Wrap and alias
        step("wrap1", 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap.pc0", bus.pc_f, 32'h0000_0000);
        step("alias", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0104);
        chk("alias.addr", {26'd0, bus.imem_addr}, 32'd1);
        step("alias.fetch", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("alias.word1", bus.instr_d, mem[1]);

        // Async reset mid-operation at PC 0x40
        step("to40a", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_003C);
        step("to40b", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("to40.pc", bus.pc_f, 32'h0000_0040);
        async_reset("rst_mid");
        step("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("after_rst.word0", bus.instr_d, mem[0]);

        // Randomized control traffic
        for (int i = 0; i < 400; i++) begin
            logic sf, sd, fl, rd;
            logic [31:0] rpc;
            sf  = ($urandom_range(0, 3) == 0);
            sd  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            rpc = $urandom;
            if (i % 150 == 149) async_reset("rand_rst");
            step("rand", sf, sd, fl, rd, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
